// File: rtl/tinycpu_pkg.sv
// Shared definitions for the tinycpu trace slice.
//   core_state_e : one-hot control-state encodings of the core that matter to the tracer
//   OP_JMP       : opcode class in instr[7:6] identifying a jump
//   REC_W        : width of one trace record {seq, A, B, M, P}
//   *_LSB        : bit offsets of each record field
//   pack_rec     : assembles a record from its fields
package tinycpu_pkg;

   typedef enum logic [5:0] {
      ST_EXEC = 6'b001000,
      ST_IDLE = 6'b100000
   } core_state_e;

   localparam logic [1:0]  OP_JMP  = 2'b11;
   localparam int unsigned REC_W   = 40;
   localparam int unsigned SEQ_LSB = 32;
   localparam int unsigned A_LSB   = 24;
   localparam int unsigned B_LSB   = 16;
   localparam int unsigned M_LSB   = 8;
   localparam int unsigned P_LSB   = 0;

   function automatic logic [REC_W-1:0] pack_rec(input logic [7:0] seq,
                                                 input logic [7:0] a,
                                                 input logic [7:0] b,
                                                 input logic [7:0] m,
                                                 input logic [7:0] p);
      logic [REC_W-1:0] rec;
      rec                = '0;
      rec[SEQ_LSB +: 8]  = seq;
      rec[A_LSB   +: 8]  = a;
      rec[B_LSB   +: 8]  = b;
      rec[M_LSB   +: 8]  = m;
      rec[P_LSB   +: 8]  = p;
      return rec;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding trace records.
//   clk      : clock, all updates on posedge
//   reset    : asynchronous active-low reset, empties the FIFO
//   wr_en    : push request (ignored when full unless a pop happens the same cycle)
//   wr_data  : record to push
//   rd_en    : pop request (ignored when empty)
//   rd_data  : head record, zero while empty
//   empty    : no entries stored
//   full     : DEPTH entries stored
module trace_fifo
   import tinycpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [REC_W-1:0] wr_data,
   input  logic             rd_en,
   output logic [REC_W-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [REC_W-1:0] mem [DEPTH];
   logic             do_wr;
   logic             do_rd;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign do_rd = rd_en && !empty;
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_wr = wr_en && (!full || do_rd);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tinycpu_trace_unit.sv
// Retirement tracer for the tinycpu core.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   state_in     : core one-hot control state
//   instr_in     : current instruction
//   ra_in..rp_in : architectural registers A, B, M, P
//   trace_valid  : head record available
//   trace_ready  : consumer accepts head
//   trace_data   : head record {seq, A, B, M, P}
//   halted       : sticky jump-to-self detected
//   instr_count  : saturating count of retire events
//   drop_count   : saturating count of records lost to a full FIFO
//   overflow     : sticky, at least one record dropped
module tinycpu_trace_unit
   import tinycpu_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned DROP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        state_in,
   input  logic [7:0]        instr_in,
   input  logic [7:0]        ra_in,
   input  logic [7:0]        rb_in,
   input  logic [7:0]        rm_in,
   input  logic [7:0]        rp_in,
   output logic              trace_valid,
   input  logic              trace_ready,
   output logic [REC_W-1:0]  trace_data,
   output logic              halted,
   output logic [CNT_W-1:0]  instr_count,
   output logic [DROP_W-1:0] drop_count,
   output logic              overflow
);

   logic             prev_idle;
   logic [7:0]       seq;
   logic             is_idle;
   logic             retire;
   logic             event_ok;
   logic             pop;
   logic             push;
   logic             drop;
   logic             fifo_empty;
   logic             fifo_full;
   logic [7:0]       rp_dec;
   logic             halt_hit;
   logic [REC_W-1:0] rec;

   assign is_idle  = (state_in == ST_IDLE);
   assign retire   = is_idle && !prev_idle;
   assign event_ok = retire && !halted;

   assign trace_valid = !fifo_empty;
   assign pop         = trace_valid && trace_ready;
   assign push        = event_ok && (!fifo_full || pop);
   assign drop        = event_ok && fifo_full && !pop;

   // P already points past the jump, so P-1 == M means the jump targets itself.
   assign rp_dec   = rp_in - 8'd1;
   assign halt_hit = (state_in == ST_EXEC) && (instr_in[7:6] == OP_JMP) && (rp_dec == rm_in);

   assign rec = pack_rec(seq, ra_in, rb_in, rm_in, rp_in);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_idle   <= 1'b0;
         seq         <= '0;
         halted      <= 1'b0;
         instr_count <= '0;
         drop_count  <= '0;
         overflow    <= 1'b0;
      end else begin
         prev_idle <= is_idle;
         if (halt_hit) halted <= 1'b1;
         if (event_ok) begin
            // seq advances on drops too, so the consumer can see the gap.
            seq <= seq + 8'd1;
            if (instr_count != '1) instr_count <= instr_count + 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
         end
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push),
      .wr_data (rec),
      .rd_en   (pop),
      .rd_data (trace_data),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

endmodule

// File: tb/tb_tinycpu_trace_unit.sv
module tb_tinycpu_trace_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  state_in;
   logic [7:0]  instr_in;
   logic [7:0]  ra_in, rb_in, rm_in, rp_in;
   logic        trace_valid;
   logic        trace_ready;
   logic [39:0] trace_data;
   logic        halted;
   logic [15:0] instr_count;
   logic [7:0]  drop_count;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] S_IDLE = 6'b100000;
   localparam logic [5:0] S_EXEC = 6'b001000;

   tinycpu_trace_unit #(
      .DEPTH  (4),
      .CNT_W  (16),
      .DROP_W (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .state_in    (state_in),
      .instr_in    (instr_in),
      .ra_in       (ra_in),
      .rb_in       (rb_in),
      .rm_in       (rm_in),
      .rp_in       (rp_in),
      .trace_valid (trace_valid),
      .trace_ready (trace_ready),
      .trace_data  (trace_data),
      .halted      (halted),
      .instr_count (instr_count),
      .drop_count  (drop_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [39:0] exp_rec(input logic [7:0] seq, input logic [7:0] i);
      logic [7:0] a, b, m, p;
      a = 8'h10 + i;
      b = 8'h20 + i;
      m = 8'h30 + i;
      p = 8'h40 + i;
      return {seq, a, b, m, p};
   endfunction

   // One IDLE-entry cycle with registers derived from i, then back to EXEC.
   task automatic do_retire(input logic [7:0] i);
      state_in = S_IDLE;
      ra_in = 8'h10 + i;
      rb_in = 8'h20 + i;
      rm_in = 8'h30 + i;
      rp_in = 8'h40 + i;
      tick();
      state_in = S_EXEC;
      instr_in = 8'h00;
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      state_in = S_EXEC;
      instr_in = 8'h00;
      ra_in = 8'h00; rb_in = 8'h00; rm_in = 8'h00; rp_in = 8'h00;
      trace_ready = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      trace_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         state_in = 6'($urandom);
         instr_in = 8'($urandom);
         ra_in = 8'($urandom); rb_in = 8'($urandom);
         rm_in = 8'($urandom); rp_in = 8'($urandom);
         trace_ready = 1'($urandom);
         tick();
         checks++;
         if ({trace_valid, trace_data, halted, instr_count, drop_count, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h halted=%b cnt=%h drop=%h ovf=%b, required all zero",
                     trace_valid, trace_data, halted, instr_count, drop_count, overflow);
         end
      end
      // Release straight into IDLE: first IDLE after reset retires.
      state_in = S_IDLE;
      instr_in = 8'h00;
      ra_in = 8'hAA; rb_in = 8'hBB; rm_in = 8'hCC; rp_in = 8'hDD;
      trace_ready = 1'b0;
      reset = 1'b1;
      tick();
      checks++;
      if (trace_valid !== 1'b1 || trace_data !== 40'h00_AA_BB_CC_DD) begin
         errors++;
         $display("FAIL first_idle_record: got valid=%b data=%h, required 1 00aabbccdd", trace_valid, trace_data);
      end
      state_in = S_EXEC;
      trace_ready = 1'b1;
      tick();
      checks++;
      if (trace_valid !== 1'b0 || instr_count !== 16'd1) begin
         errors++;
         $display("FAIL first_idle_pop: got valid=%b cnt=%0d, required 0 1", trace_valid, instr_count);
      end
   endtask

   task automatic test_single();
      do_reset();
      trace_ready = 1'b1;
      state_in = S_IDLE;
      ra_in = 8'h01; rb_in = 8'h02; rm_in = 8'h03; rp_in = 8'h04;
      tick();
      checks++;
      if (trace_valid !== 1'b1 || trace_data !== 40'h00_01_02_03_04 || instr_count !== 16'd1) begin
         errors++;
         $display("FAIL single_record: got valid=%b data=%h cnt=%0d, required 1 0001020304 1",
                  trace_valid, trace_data, instr_count);
      end
      state_in = S_EXEC;
      tick();
      checks++;
      if (trace_valid !== 1'b0 || trace_data !== 40'h0 || instr_count !== 16'd1) begin
         errors++;
         $display("FAIL single_consumed: got valid=%b data=%h cnt=%0d, required 0 0 1",
                  trace_valid, trace_data, instr_count);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 6; i++) do_retire(8'(i));
      checks++;
      if (drop_count !== 8'd2 || overflow !== 1'b1 || instr_count !== 16'd6 || trace_valid !== 1'b1) begin
         errors++;
         $display("FAIL overflow_counts: got drop=%0d ovf=%b cnt=%0d valid=%b, required 2 1 6 1",
                  drop_count, overflow, instr_count, trace_valid);
      end
      trace_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (trace_data !== exp_rec(8'(i), 8'(i))) begin
            errors++;
            $display("FAIL overflow_drain_%0d: got %h, required %h", i, trace_data, exp_rec(8'(i), 8'(i)));
         end
         tick();
      end
      checks++;
      if (trace_valid !== 1'b0) begin
         errors++;
         $display("FAIL overflow_empty: got valid=%b, required 0", trace_valid);
      end
      trace_ready = 1'b0;
      do_retire(8'd6);
      checks++;
      if (trace_data !== exp_rec(8'd6, 8'd6)) begin
         errors++;
         $display("FAIL seq_gap: got %h, required %h", trace_data, exp_rec(8'd6, 8'd6));
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 4; i++) do_retire(8'(i));
      // Full FIFO, retire and pop in the same cycle.
      state_in = S_IDLE;
      ra_in = 8'h14; rb_in = 8'h24; rm_in = 8'h34; rp_in = 8'h44;
      trace_ready = 1'b1;
      tick();
      state_in = S_EXEC;
      checks++;
      if (drop_count !== 8'd0 || overflow !== 1'b0 || instr_count !== 16'd5) begin
         errors++;
         $display("FAIL full_push_pop_counts: got drop=%0d ovf=%b cnt=%0d, required 0 0 5",
                  drop_count, overflow, instr_count);
      end
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (trace_valid !== 1'b1 || trace_data !== exp_rec(8'(k), 8'(k))) begin
            errors++;
            $display("FAIL full_push_pop_drain_%0d: got valid=%b data=%h, required 1 %h",
                     k, trace_valid, trace_data, exp_rec(8'(k), 8'(k)));
         end
         tick();
      end
      checks++;
      if (trace_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_push_pop_empty: got valid=%b, required 0", trace_valid);
      end
   endtask

   task automatic test_halt();
      do_reset();
      do_retire(8'd0);
      do_retire(8'd1);
      // Near misses: jump with P-1 != M, and non-jump with P-1 == M.
      state_in = S_EXEC; instr_in = 8'hC0; rp_in = 8'h05; rm_in = 8'h03;
      tick();
      instr_in = 8'h80; rp_in = 8'h04; rm_in = 8'h03;
      tick();
      state_in = 6'b101000; instr_in = 8'hC0; rp_in = 8'h04; rm_in = 8'h03;
      tick();
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_false_trigger: got halted=%b, required 0", halted);
      end
      state_in = S_EXEC; instr_in = 8'hC0; rp_in = 8'h00; rm_in = 8'hFF;
      tick();
      instr_in = 8'h00;
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_wrap_detect: got halted=%b, required 1", halted);
      end
      do_retire(8'd2);
      do_retire(8'd3);
      checks++;
      if (halted !== 1'b1 || instr_count !== 16'd2 || drop_count !== 8'd0) begin
         errors++;
         $display("FAIL halt_frozen: got halted=%b cnt=%0d drop=%0d, required 1 2 0",
                  halted, instr_count, drop_count);
      end
      trace_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (trace_valid !== 1'b1 || trace_data !== exp_rec(8'(i), 8'(i))) begin
            errors++;
            $display("FAIL halt_drain_%0d: got valid=%b data=%h, required 1 %h",
                     i, trace_valid, trace_data, exp_rec(8'(i), 8'(i)));
         end
         tick();
      end
      checks++;
      if (trace_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_drained_empty: got valid=%b, required 0", trace_valid);
      end
   endtask

   task automatic test_drop_saturation();
      do_reset();
      for (int i = 0; i < 264; i++) do_retire(8'(i));
      checks++;
      if (drop_count !== 8'd255 || overflow !== 1'b1 || instr_count !== 16'd264 ||
          trace_data !== exp_rec(8'd0, 8'd0)) begin
         errors++;
         $display("FAIL drop_saturate: got drop=%0d ovf=%b cnt=%0d head=%h, required 255 1 264 %h",
                  drop_count, overflow, instr_count, trace_data, exp_rec(8'd0, 8'd0));
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      state_in = S_IDLE;
      ra_in = 8'h10; rb_in = 8'h20; rm_in = 8'h30; rp_in = 8'h40;
      for (int c = 0; c < 5; c++) tick();
      checks++;
      if (instr_count !== 16'd1 || trace_data !== exp_rec(8'd0, 8'd0)) begin
         errors++;
         $display("FAIL idle_hold_one: got cnt=%0d head=%h, required 1 %h",
                  instr_count, trace_data, exp_rec(8'd0, 8'd0));
      end
      state_in = S_EXEC;
      trace_ready = 1'b1;
      tick();
      checks++;
      if (trace_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold_single_entry: got valid=%b, required 0", trace_valid);
      end
      trace_ready = 1'b0;
      for (int i = 0; i < 3; i++) do_retire(8'(i));
      checks++;
      if (trace_valid !== 1'b1 || instr_count !== 16'd4) begin
         errors++;
         $display("FAIL pre_reset_queue: got valid=%b cnt=%0d, required 1 4", trace_valid, instr_count);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (trace_valid !== 1'b0 || trace_data !== 40'h0 || instr_count !== 16'd0) begin
         errors++;
         $display("FAIL async_reset_flush: got valid=%b data=%h cnt=%0d, required 0 0 0",
                  trace_valid, trace_data, instr_count);
      end
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      state_in = S_EXEC;
      instr_in = 8'h00;
      ra_in = 8'h00; rb_in = 8'h00; rm_in = 8'h00; rp_in = 8'h00;
      trace_ready = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_full_push_pop();
      test_halt();
      test_drop_saturation();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
